seq_arith_8b_accum_window: RTL and testbench



---
 rtl/seq_arith_8b_accum_window.sv | 168 ++++++++++++++++
 tb/tb_seq_arith_8b_accum_window.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_arith_8b_accum_window.sv
// rtl/seq_arith_8b_accum_window.sv - windowed increment sum and wrap count behind an accumulator, 2-entry result FIFO
module seq_arith_8b_accum_window #(
    parameter int WIN = 4,
    parameter int SW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_val,
    input  logic [7:0]    in_,
    output logic          out_val,
    input  logic          out_rdy,
    output logic [SW-1:0] out_sum,
    output logic [7:0]    out_wraps,
    output logic          drop
);

    // Index of the sample that closes a window (count runs 0..WIN-1).
    localparam logic [7:0] LAST_IDX = 8'(WIN - 1);

    // Window accumulation state.
    logic [7:0]    prev_q,  prev_d;
    logic [7:0]    count_q, count_d;
    logic [SW-1:0] sum_q,   sum_d;
    logic [7:0]    wraps_q, wraps_d;

    // Result FIFO: slot0 is the head and drives the outputs directly.
    logic          val0_q,        val0_d;
    logic          val1_q,        val1_d;
    logic [SW-1:0] slot0_sum_q,   slot0_sum_d;
    logic [SW-1:0] slot1_sum_q,   slot1_sum_d;
    logic [7:0]    slot0_wraps_q, slot0_wraps_d;
    logic [7:0]    slot1_wraps_q, slot1_wraps_d;
    logic          drop_q,        drop_d;

    // Per-sample decode.
    logic [7:0]    delta;
    logic          wrap;
    logic [SW-1:0] sum_next;
    logic [7:0]    wraps_next;
    logic          close;
    logic          push;
    logic          pop;

    // Recover the increment as a mod-256 difference; a smaller new value means the accumulator wrapped.
    always_comb begin
        delta      = in_ - prev_q;
        wrap       = (in_ < prev_q);
        sum_next   = sum_q + SW'(delta);
        wraps_next = (wrap && (wraps_q != 8'hFF)) ? wraps_q + 8'd1 : wraps_q;
        close      = in_val && (count_q == LAST_IDX);
        push       = close;
        pop        = val0_q && out_rdy;
    end

    // Window counters: advance on each valid sample, clear on the closing one; prev always tracks the input.
    always_comb begin
        prev_d  = prev_q;
        count_d = count_q;
        sum_d   = sum_q;
        wraps_d = wraps_q;
        if (in_val) begin
            prev_d = in_;
            if (close) begin
                count_d = '0;
                sum_d   = '0;
                wraps_d = '0;
            end else begin
                count_d = count_q + 8'd1;
                sum_d   = sum_next;
                wraps_d = wraps_next;
            end
        end
    end

    // FIFO update: pop is applied before push so a full FIFO being drained can still accept a result.
    always_comb begin
        val0_d        = val0_q;
        val1_d        = val1_q;
        slot0_sum_d   = slot0_sum_q;
        slot1_sum_d   = slot1_sum_q;
        slot0_wraps_d = slot0_wraps_q;
        slot1_wraps_d = slot1_wraps_q;
        drop_d        = drop_q;
        case ({val1_q, val0_q})
            2'b00: begin
                if (push) begin
                    val0_d        = 1'b1;
                    slot0_sum_d   = sum_next;
                    slot0_wraps_d = wraps_next;
                end
            end
            2'b01: begin
                if (pop && push) begin
                    slot0_sum_d   = sum_next;
                    slot0_wraps_d = wraps_next;
                end else if (pop) begin
                    val0_d        = 1'b0;
                    slot0_sum_d   = '0;
                    slot0_wraps_d = '0;
                end else if (push) begin
                    val1_d        = 1'b1;
                    slot1_sum_d   = sum_next;
                    slot1_wraps_d = wraps_next;
                end
            end
            2'b11: begin
                if (pop) begin
                    slot0_sum_d   = slot1_sum_q;
                    slot0_wraps_d = slot1_wraps_q;
                    if (push) begin
                        slot1_sum_d   = sum_next;
                        slot1_wraps_d = wraps_next;
                    end else begin
                        val1_d        = 1'b0;
                        slot1_sum_d   = '0;
                        slot1_wraps_d = '0;
                    end
                end else if (push) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                // Slot1 valid without slot0 cannot arise; fall back to empty.
                val0_d        = 1'b0;
                val1_d        = 1'b0;
                slot0_sum_d   = '0;
                slot1_sum_d   = '0;
                slot0_wraps_d = '0;
                slot1_wraps_d = '0;
            end
        endcase
    end

    // State registers; reset discards any partial window and all buffered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q        <= '0;
            count_q       <= '0;
            sum_q         <= '0;
            wraps_q       <= '0;
            val0_q        <= 1'b0;
            val1_q        <= 1'b0;
            slot0_sum_q   <= '0;
            slot1_sum_q   <= '0;
            slot0_wraps_q <= '0;
            slot1_wraps_q <= '0;
            drop_q        <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            wraps_q       <= wraps_d;
            val0_q        <= val0_d;
            val1_q        <= val1_d;
            slot0_sum_q   <= slot0_sum_d;
            slot1_sum_q   <= slot1_sum_d;
            slot0_wraps_q <= slot0_wraps_d;
            slot1_wraps_q <= slot1_wraps_d;
            drop_q        <= drop_d;
        end
    end

    assign out_val   = val0_q;
    assign out_sum   = slot0_sum_q;
    assign out_wraps = slot0_wraps_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_seq_arith_8b_accum_window.sv
// tb/tb_seq_arith_8b_accum_window.sv - self-checking bench for seq_arith_8b_accum_window
module tb_seq_arith_8b_accum_window;

    localparam int WIN = 4;
    localparam int SW  = 16;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          in_val  = 1'b0;
    logic [7:0]    in_     = 8'd0;
    logic          out_rdy = 1'b1;
    logic          out_val;
    logic [SW-1:0] out_sum;
    logic [7:0]    out_wraps;
    logic          drop;

    int checks = 0;
    int errors = 0;

    seq_arith_8b_accum_window #(.WIN(WIN), .SW(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .in_       (in_),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_sum   (out_sum),
        .out_wraps (out_wraps),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: keeps the window's increments and wrap flags as lists, results as a queue.
    int m_prev;
    int m_d[$];
    int m_w[$];
    int f_sum[$];
    int f_wr[$];
    bit m_drop;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev = 0;
            m_d.delete();
            m_w.delete();
            f_sum.delete();
            f_wr.delete();
            m_drop = 0;
        end else begin
            if (f_sum.size() > 0 && out_rdy) begin
                void'(f_sum.pop_front());
                void'(f_wr.pop_front());
            end
            if (in_val) begin
                m_d.push_back((int'(in_) - m_prev + 256) % 256);
                m_w.push_back((int'(in_) < m_prev) ? 1 : 0);
                m_prev = int'(in_);
                if (m_d.size() == WIN) begin
                    int s;
                    int w;
                    s = 0;
                    w = 0;
                    foreach (m_d[i]) s += m_d[i];
                    foreach (m_w[i]) w += m_w[i];
                    if (w > 255) w = 255;
                    if (f_sum.size() < 2) begin
                        f_sum.push_back(s);
                        f_wr.push_back(w);
                    end else begin
                        m_drop = 1;
                    end
                    m_d.delete();
                    m_w.delete();
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_out_val", 32'(out_val), (f_sum.size() > 0) ? 32'd1 : 32'd0);
        check("model_out_sum", 32'(out_sum), (f_sum.size() > 0) ? 32'(f_sum[0]) : 32'd0);
        check("model_out_wraps", 32'(out_wraps), (f_wr.size() > 0) ? 32'(f_wr[0]) : 32'd0);
        check("model_drop", 32'(drop), 32'(m_drop));
    end

    task automatic feed(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_val = v;
        in_    = d;
    endtask

    task automatic idle();
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset_out_val", 32'(out_val), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_wraps", 32'(out_wraps), 32'd0);
        check("reset_drop", 32'(drop), 32'd0);

        // Simple ascending window.
        out_rdy = 1'b1;
        feed(1, 8'd10); feed(1, 8'd30); feed(1, 8'd60); feed(1, 8'd100);
        idle();
        check("t1_out_val", 32'(out_val), 32'd1);
        check("t1_out_sum", 32'(out_sum), 32'd100);
        check("t1_out_wraps", 32'(out_wraps), 32'd0);
        idle();
        check("t1_popped", 32'(out_val), 32'd0);

        // One wrap inside the window.
        do_reset();
        feed(1, 8'd200); feed(1, 8'd44); feed(1, 8'd144); feed(1, 8'd244);
        idle();
        check("t2_out_sum", 32'(out_sum), 32'd500);
        check("t2_out_wraps", 32'(out_wraps), 32'd1);

        // Maximum increments.
        do_reset();
        feed(1, 8'd255); feed(1, 8'd254); feed(1, 8'd253); feed(1, 8'd252);
        idle();
        check("t3_out_sum", 32'(out_sum), 32'd1020);
        check("t3_out_wraps", 32'(out_wraps), 32'd3);

        // in_val gaps; no result before the fourth valid sample.
        do_reset();
        feed(1, 8'd5); feed(0, 8'd9); feed(0, 8'd9); feed(1, 8'd9); feed(1, 8'd20); feed(0, 8'd20);
        @(negedge clk);
        check("t4_latency", 32'(out_val), 32'd0);
        in_val = 1'b1;
        in_    = 8'd26;
        idle();
        check("t4_out_val", 32'(out_val), 32'd1);
        check("t4_out_sum", 32'(out_sum), 32'd26);

        // Back-pressure: two results held, third dropped.
        do_reset();
        out_rdy = 1'b0;
        for (int i = 1; i <= 12; i++) feed(1, 8'(i));
        idle();
        check("t5_out_val", 32'(out_val), 32'd1);
        check("t5_head_sum", 32'(out_sum), 32'd4);
        check("t5_drop", 32'(drop), 32'd1);
        out_rdy = 1'b1;
        @(negedge clk);
        check("t5_second_sum", 32'(out_sum), 32'd4);
        check("t5_second_val", 32'(out_val), 32'd1);
        @(negedge clk);
        check("t5_drained", 32'(out_val), 32'd0);
        check("t5_drop_sticky", 32'(drop), 32'd1);

        // Asynchronous reset mid-window with a buffered result.
        out_rdy = 1'b0;
        feed(1, 8'd13); feed(1, 8'd14); feed(1, 8'd15); feed(1, 8'd16);
        feed(1, 8'd17); feed(1, 8'd18);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("t6_async_out_val", 32'(out_val), 32'd0);
        check("t6_async_drop", 32'(drop), 32'd0);
        check("t6_async_out_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        in_val = 1'b0;
        #2 reset = 1'b0;
        out_rdy = 1'b1;
        feed(1, 8'd3); feed(1, 8'd6); feed(1, 8'd9); feed(1, 8'd12);
        idle();
        check("t6_out_val", 32'(out_val), 32'd1);
        check("t6_out_sum", 32'(out_sum), 32'd12);
        check("t6_out_wraps", 32'(out_wraps), 32'd0);
        repeat (3) idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
